// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states and bus timing constants.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_ADDR,
      WR_DATA,
      ACK_DATA,
      RD_DATA,
      MST_ACK,
      WAIT_STOP
   } slave_state_t;

   localparam int unsigned SYS_FREQ  = 40_000_000;
   localparam int unsigned I2C_FREQ  = 100_000;
   localparam int unsigned MEM_DEPTH = 128;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes scl/sda into the clk domain and flags scl edges plus START/STOP.
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_q;
   logic [SYNC_STAGES-1:0] sda_q;
   logic                   scl_p;
   logic                   sda_p;
   logic                   scl_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_q <= '1;
         sda_q <= '1;
         scl_p <= 1'b1;
         sda_p <= 1'b1;
      end else begin
         scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
         sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
         scl_p <= scl_q[SYNC_STAGES-1];
         sda_p <= sda_q[SYNC_STAGES-1];
      end
   end

   assign scl_now   = scl_q[SYNC_STAGES-1];
   assign sda_s     = sda_q[SYNC_STAGES-1];
   assign scl_rise  = scl_now & ~scl_p;
   assign scl_fall  = ~scl_now & scl_p;
   // scl must be high on both samples so an scl edge is never mistaken for START/STOP
   assign start_det = scl_now & scl_p & sda_p & ~sda_s;
   assign stop_det  = scl_now & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Single-target I2C responder: 7-bit address selects a byte in a 128x8 memory.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   output logic       busy,
   output logic       done,
   output logic [6:0] last_addr,
   output logic       last_op,
   output logic [7:0] last_data
);

   slave_state_t state;
   logic [3:0]   bitcnt;
   logic [7:0]   shift;
   logic [7:0]   data;
   logic [6:0]   addr;
   logic         op;
   logic         sda_en;
   logic         sda_t;
   logic [7:0]   mem [MEM_DEPTH];

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic start_ok, stop_ok;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign sda      = sda_en ? sda_t : 1'bz;
   // our own sda transitions must never look like bus conditions
   assign start_ok = start_det & ~sda_en;
   assign stop_ok  = stop_det & ~sda_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bitcnt    <= '0;
         shift     <= '0;
         data      <= '0;
         addr      <= '0;
         op        <= 1'b0;
         sda_en    <= 1'b0;
         sda_t     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         last_addr <= '0;
         last_op   <= 1'b0;
         last_data <= '0;
         for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'(i);
      end else begin
         done <= 1'b0;
         if (start_ok) begin
            state  <= ADDR;
            bitcnt <= '0;
            sda_en <= 1'b0;
            busy   <= 1'b1;
         end else if (stop_ok && state != IDLE) begin
            if (state == WAIT_STOP) begin
               done      <= 1'b1;
               last_addr <= addr;
               last_op   <= op;
               last_data <= data;
            end
            state  <= IDLE;
            sda_en <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               ADDR: begin
                  if (scl_rise) begin
                     shift  <= {shift[6:0], sda_s};
                     bitcnt <= bitcnt + 4'd1;
                  end else if (scl_fall && bitcnt == 4'd8) begin
                     addr   <= shift[7:1];
                     op     <= shift[0];
                     sda_en <= 1'b1;
                     sda_t  <= 1'b0;
                     state  <= ACK_ADDR;
                  end
               end
               ACK_ADDR: begin
                  if (scl_fall) begin
                     bitcnt <= '0;
                     if (op) begin
                        shift <= mem[addr];
                        data  <= mem[addr];
                        sda_t <= mem[addr][7];
                        state <= RD_DATA;
                     end else begin
                        sda_en <= 1'b0;
                        state  <= WR_DATA;
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_rise) begin
                     shift  <= {shift[6:0], sda_s};
                     bitcnt <= bitcnt + 4'd1;
                  end else if (scl_fall && bitcnt == 4'd8) begin
                     mem[addr] <= shift;
                     data      <= shift;
                     sda_en    <= 1'b1;
                     sda_t     <= 1'b0;
                     state     <= ACK_DATA;
                  end
               end
               ACK_DATA: begin
                  if (scl_fall) begin
                     sda_en <= 1'b0;
                     state  <= WAIT_STOP;
                  end
               end
               RD_DATA: begin
                  if (scl_rise) begin
                     shift  <= {shift[6:0], 1'b0};
                     bitcnt <= bitcnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bitcnt == 4'd8) begin
                        sda_en <= 1'b0;
                        state  <= MST_ACK;
                     end else begin
                        sda_t <= shift[7];
                     end
                  end
               end
               MST_ACK: begin
                  if (scl_fall) state <= WAIT_STOP;
               end
               WAIT_STOP: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; a reference memory feeds a scoreboard of expected transactions.
module tb_i2c_slave;
   import i2c_pkg::*;

   localparam int unsigned Q = 20;   // clk cycles per quarter scl period

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_sda = 1'b1;
   wire        sda;
   logic       busy, done;
   logic [6:0] last_addr;
   logic       last_op;
   logic [7:0] last_data;

   int         n_tests = 0;
   int         n_fail = 0;
   int         done_cnt = 0;
   logic [15:0] sb_q [$];
   logic [7:0]  model_mem [128];

   pullup (sda);
   assign sda = m_sda ? 1'bz : 1'b0;

   always #5 clk = ~clk;

   i2c_slave #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .busy      (busy),
      .done      (done),
      .last_addr (last_addr),
      .last_op   (last_op),
      .last_data (last_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // every done pulse must match the oldest expected completed transaction
   always @(negedge clk) begin
      if (!rst && done) begin
         done_cnt++;
         if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
         else check("done_record", {16'b0, last_addr, last_op, last_data}, {16'b0, sb_q.pop_front()});
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 128; i++) model_mem[i] = 8'(i);
      sb_q.delete();
   endtask

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wq();
      scl = 1'b1;   wq();
      m_sda = 1'b0; wq();
      scl = 1'b0;   wq();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wq();
      scl = 1'b1;   wq();
      m_sda = 1'b1; wq();
   endtask

   task automatic put_bit(input logic b);
      m_sda = b; wq();
      scl = 1'b1; wq(); wq();
      scl = 1'b0; wq();
   endtask

   task automatic get_bit(output logic b);
      m_sda = 1'b1; wq();
      scl = 1'b1; wq();
      b = sda; wq();
      scl = 1'b0; wq();
   endtask

   task automatic put_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) put_bit(v[i]);
   endtask

   task automatic get_byte(output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         v[i] = b;
      end
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      logic k1, k2;
      int   d0;
      d0 = done_cnt;
      sb_q.push_back({a, 1'b0, d});
      model_mem[a] = d;
      i2c_start();
      put_byte({a, 1'b0});
      get_bit(k1);
      put_byte(d);
      get_bit(k2);
      i2c_stop();
      check("wr_ack_err", {31'b0, k1 | k2}, 0);
      check("wr_done_once", done_cnt, d0 + 1);
   endtask

   task automatic do_read(input logic [6:0] a);
      logic       k;
      logic [7:0] dout, exp;
      exp = model_mem[a];
      sb_q.push_back({a, 1'b1, exp});
      i2c_start();
      put_byte({a, 1'b1});
      get_bit(k);
      get_byte(dout);
      put_bit(1'b1);
      i2c_stop();
      check("rd_ack_err", {31'b0, k}, 0);
      check("rd_dout", {24'b0, dout}, {24'b0, exp});
   endtask

   initial begin
      logic k;
      int   d0;
      model_reset();
      repeat (5) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_last_addr", last_addr, 0);
      check("rst_last_op", last_op, 0);
      check("rst_last_data", last_data, 0);
      check("rst_sda_released", sda, 1);
      rst = 1'b0;
      wq();

      // reset contents, then boundary addresses written and read back
      do_read(7'h05);
      do_read(7'h7F);
      do_write(7'h00, 8'h3C);
      do_write(7'h7F, 8'hC3);
      do_read(7'h00);
      do_read(7'h7F);

      do_write(7'h12, 8'hA5);
      check("wr_last_addr", last_addr, 32'h12);
      check("wr_last_op", last_op, 0);
      check("wr_last_data", last_data, 32'hA5);
      do_read(7'h12);
      check("rd_last_op", last_op, 1);
      check("rd_last_data", last_data, 32'hA5);

      // reset during bit 4 of a write data byte
      do_write(7'h20, 8'h99);
      i2c_start();
      put_byte({7'h20, 1'b0});
      get_bit(k);
      check("mid_addr_ack", {31'b0, k}, 0);
      put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
      m_sda = 1'b0; wq();
      scl = 1'b1; wq();
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      m_sda = 1'b1;
      #1;
      check("mid_rst_sda", sda, 1);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wq();
      do_read(7'h20);
      do_write(7'h20, 8'h55);
      do_read(7'h20);

      // reset while the slave is driving the address ACK
      i2c_start();
      put_byte({7'h40, 1'b0});
      m_sda = 1'b1; wq();
      scl = 1'b1; wq();
      check("ack_driven", sda, 0);
      rst = 1'b1;
      #1;
      check("ack_rst_sda", sda, 1);
      check("ack_rst_busy", busy, 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wq();

      // STOP after 3 address bits aborts with no done
      d0 = done_cnt;
      i2c_start();
      put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
      i2c_stop();
      check("abort_busy", busy, 0);
      check("abort_no_done", done_cnt, d0);

      // repeated START in the middle of a write data byte
      i2c_start();
      put_byte({7'h30, 1'b0});
      get_bit(k);
      check("rs_addr_ack", {31'b0, k}, 0);
      put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
      m_sda = 1'b1; wq();
      scl = 1'b1; wq();
      m_sda = 1'b0; wq();
      check("rs_busy", busy, 1);
      check("rs_state", 32'(dut.state), 32'(ADDR));
      scl = 1'b0; wq();
      check("rs_no_done", done_cnt, d0);
      do_write(7'h01, 8'hFF);
      do_read(7'h30);
      do_read(7'h01);

      check("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
